// File: rtl/fun_dispatch.sv
// -----------------------------------------------------------------------------
// fun_dispatch
// Operand-queue front end for the fun core (result = a^2 + cbrt(b)).
// Incoming (a,b) pairs are buffered in a small FIFO. They are issued one at a
// time over fun's start/busy handshake. Each 16-bit result is captured with a
// sequence tag and presented on a valid/ready port.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_i        : synchronous reset, active-low
//   in_valid_i   : operand pair valid
//   in_ready_o   : FIFO not full
//   in_a_i/in_b_i: operands (a squared, b cube-rooted by fun)
//   fun_start_o  : one-cycle start pulse to fun
//   fun_a_o/_b_o : registered operands to fun, held from pop to next pop
//   fun_busy_i   : fun busy_o
//   fun_result_i : fun result
//   res_valid_o  : result register occupied
//   res_ready_i  : consumer accepts result
//   res_data_o   : captured result
//   res_tag_o    : sequence tag of the job that produced res_data_o
//   level_o      : FIFO occupancy
//   err_o        : sticky protocol error (fun never went busy after a start)
// -----------------------------------------------------------------------------
module fun_dispatch #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [7:0]                 in_a_i,
    input  logic [7:0]                 in_b_i,
    output logic                       fun_start_o,
    output logic [7:0]                 fun_a_o,
    output logic [7:0]                 fun_b_o,
    input  logic                       fun_busy_i,
    input  logic [15:0]                fun_result_i,
    output logic                       res_valid_o,
    input  logic                       res_ready_i,
    output logic [15:0]                res_data_o,
    output logic [TAG_W-1:0]           res_tag_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
    localparam logic [LVL_W-1:0] LVL_ONE  = {{(LVL_W-1){1'b0}}, 1'b1};
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [TAG_W-1:0] TAG_ONE  = {{(TAG_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;

    logic [7:0]         mem_a_r [DEPTH];
    logic [7:0]         mem_b_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [LVL_W-1:0]   level_r;
    logic [LVL_W-1:0]   level_next_s;
    logic               in_ready_r;

    logic               fun_start_r;
    logic [7:0]         fun_a_r;
    logic [7:0]         fun_b_r;
    logic [TAG_W-1:0]   tag_cnt_r;
    logic [TAG_W-1:0]   job_tag_r;
    logic               first_wait_r;

    logic               res_valid_r;
    logic [15:0]        res_data_r;
    logic [TAG_W-1:0]   res_tag_r;
    logic               err_r;

    logic               push_s;
    logic               issue_s;
    logic               capture_s;
    logic               err_set_s;

    // in_ready_r is the registered "not full" flag, so push never overfills
    assign push_s = in_valid_i && in_ready_r;

    // FSM next state and issue/capture/error decisions
    always_comb begin
        state_next_s = state_r;
        issue_s      = 1'b0;
        capture_s    = 1'b0;
        err_set_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                // fun may still read busy after reset; wait until it is idle
                if ((level_r != LVL_ZERO) && !fun_busy_i) begin
                    issue_s      = 1'b1;
                    state_next_s = S_START;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_START: begin
                state_next_s = S_WAIT;
            end
            S_WAIT: begin
                // fun should be busy on the first edge after the start pulse
                if (first_wait_r && !fun_busy_i) begin
                    err_set_s = 1'b1;
                end else begin
                    err_set_s = 1'b0;
                end
                if (!fun_busy_i && (!res_valid_r || res_ready_i)) begin
                    capture_s    = 1'b1;
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // FIFO occupancy after this edge's push and pop
    always_comb begin
        level_next_s = level_r;
        case ({push_s, issue_s})
            2'b10:   level_next_s = level_r + LVL_ONE;
            2'b01:   level_next_s = level_r - LVL_ONE;
            default: level_next_s = level_r;
        endcase
    end

    // FIFO storage and pointers
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a_r[i] <= 8'd0;
                mem_b_r[i] <= 8'd0;
            end
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            level_r    <= LVL_ZERO;
            in_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                mem_a_r[wr_ptr_r] <= in_a_i;
                mem_b_r[wr_ptr_r] <= in_b_i;
                wr_ptr_r          <= wr_ptr_r + PTR_ONE;
            end
            if (issue_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r    <= level_next_s;
            in_ready_r <= (level_next_s != LVL_FULL);
        end
    end

    // FSM state, issue-side registers and job tagging
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r      <= S_IDLE;
            fun_start_r  <= 1'b0;
            fun_a_r      <= 8'd0;
            fun_b_r      <= 8'd0;
            tag_cnt_r    <= {TAG_W{1'b0}};
            job_tag_r    <= {TAG_W{1'b0}};
            first_wait_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            // start pulse is high exactly for the S_START cycle
            fun_start_r  <= issue_s;
            first_wait_r <= (state_r == S_START);
            if (issue_s) begin
                fun_a_r   <= mem_a_r[rd_ptr_r];
                fun_b_r   <= mem_b_r[rd_ptr_r];
                job_tag_r <= tag_cnt_r;
                tag_cnt_r <= tag_cnt_r + TAG_ONE;
            end
        end
    end

    // Result register, output handshake and sticky error flag
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            res_valid_r <= 1'b0;
            res_data_r  <= 16'd0;
            res_tag_r   <= {TAG_W{1'b0}};
            err_r       <= 1'b0;
        end else begin
            if (capture_s) begin
                res_valid_r <= 1'b1;
                res_data_r  <= fun_result_i;
                res_tag_r   <= job_tag_r;
            end else if (res_ready_i) begin
                res_valid_r <= 1'b0;
            end
            if (err_set_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign in_ready_o  = in_ready_r;
    assign fun_start_o = fun_start_r;
    assign fun_a_o     = fun_a_r;
    assign fun_b_o     = fun_b_r;
    assign res_valid_o = res_valid_r;
    assign res_data_o  = res_data_r;
    assign res_tag_o   = res_tag_r;
    assign level_o     = level_r;
    assign err_o       = err_r;

endmodule

// File: tb/tb_fun_dispatch.sv
// -----------------------------------------------------------------------------
// tb_fun_dispatch
// Scoreboard bench for fun_dispatch. A behavioural fun model answers the
// start/busy handshake. Every issued job pushes its expected {result, tag}
// into a queue. A monitor pops and compares on each accepted result.
// -----------------------------------------------------------------------------
module tb_fun_dispatch;

    localparam int DEPTH = 4;
    localparam int TAG_W = 8;
    localparam int LAT   = 3;

    logic        clk_i;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [7:0]  in_a_i;
    logic [7:0]  in_b_i;
    logic        fun_start_o;
    logic [7:0]  fun_a_o;
    logic [7:0]  fun_b_o;
    logic        fun_busy_i;
    logic [15:0] fun_result_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [15:0] res_data_o;
    logic [7:0]  res_tag_o;
    logic [2:0]  level_o;
    logic        err_o;

    fun_dispatch #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_a_i       (in_a_i),
        .in_b_i       (in_b_i),
        .fun_start_o  (fun_start_o),
        .fun_a_o      (fun_a_o),
        .fun_b_o      (fun_b_o),
        .fun_busy_i   (fun_busy_i),
        .fun_result_i (fun_result_i),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_data_o   (res_data_o),
        .res_tag_o    (res_tag_o),
        .level_o      (level_o),
        .err_o        (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [15:0] data;
        logic [7:0]  tag;
    } exp_t;

    exp_t       exp_q[$];
    int         pass_cnt  = 0;
    int         total_cnt = 0;
    int         start_cnt = 0;
    logic [7:0] tb_tag;
    logic       fault_mode;

    // fun model state
    logic        fm_busy;
    logic [15:0] fm_result;
    logic [15:0] fm_pend;
    int          fm_cnt;

    assign fun_busy_i   = fm_busy;
    assign fun_result_i = fm_result;

    function automatic logic [15:0] fun_ref(input logic [7:0] a, input logic [7:0] b);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= int'(b)) r++;
        return 16'(int'(a) * int'(a) + r);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Behavioural fun: goes busy on start, result appears when busy drops
    always @(posedge clk_i) begin
        if (!rst_i) begin
            fm_busy   <= 1'b0;
            fm_result <= 16'd0;
            fm_pend   <= 16'd0;
            fm_cnt    <= 0;
        end else if (fm_busy) begin
            if (fm_cnt == 0) begin
                fm_busy   <= 1'b0;
                fm_result <= fm_pend;
            end else begin
                fm_cnt <= fm_cnt - 1;
            end
        end else if (fun_start_o && !fault_mode) begin
            fm_busy <= 1'b1;
            fm_cnt  <= LAT;
            fm_pend <= fun_ref(fun_a_o, fun_b_o);
        end
    end

    // Result monitor: compare each accepted result against the scoreboard
    always @(negedge clk_i) begin
        if (rst_i && res_valid_o && res_ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(res_data_o), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("res_data", 32'(res_data_o), 32'(e.data));
                check("res_tag", 32'(res_tag_o), 32'(e.tag));
            end
        end
    end

    // Start monitor: never start while fun is busy; count starts
    always @(negedge clk_i) begin
        if (rst_i && fun_start_o) begin
            check("start_while_busy", 32'(fun_busy_i), 32'd0);
            start_cnt++;
        end
    end

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp_data);
        int   n;
        exp_t e;
        n = 0;
        while (!in_ready_o && n < 500) begin
            tick();
            n++;
        end
        if (!in_ready_o) begin
            check("push_ready_timeout", 32'(in_ready_o), 32'd1);
            return;
        end
        in_a_i     = a;
        in_b_i     = b;
        in_valid_i = 1'b1;
        e.data     = exp_data;
        e.tag      = tb_tag;
        exp_q.push_back(e);
        tb_tag     = tb_tag + 8'd1;
        tick();
        in_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_i      = 1'b0;
        in_valid_i = 1'b0;
        tick();
        check("rst_res_valid", 32'(res_valid_o), 32'd0);
        check("rst_res_data", 32'(res_data_o), 32'd0);
        check("rst_res_tag", 32'(res_tag_o), 32'd0);
        check("rst_level", 32'(level_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_in_ready", 32'(in_ready_o), 32'd1);
        check("rst_start", 32'(fun_start_o), 32'd0);
        check("rst_fun_a", 32'(fun_a_o), 32'd0);
        check("rst_fun_b", 32'(fun_b_o), 32'd0);
        exp_q.delete();
        tb_tag = 8'd0;
        rst_i  = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    logic [7:0]  va [6];
    logic [15:0] vr [6];
    int          s0;
    int          n;
    int          vcnt;

    initial begin
        rst_i       = 1'b0;
        in_valid_i  = 1'b0;
        in_a_i      = 8'd0;
        in_b_i      = 8'd0;
        res_ready_i = 1'b0;
        fault_mode  = 1'b0;
        tb_tag      = 8'd0;
        repeat (2) tick();
        do_reset();

        // 1: single job, latency and hold while not ready (9 + 3 = 12)
        res_ready_i = 1'b0;
        push(8'd3, 8'd27, 16'd12);
        check("t1_level_e0", 32'(level_o), 32'd1);
        check("t1_start_e0", 32'(fun_start_o), 32'd0);
        tick();
        check("t1_start_e1", 32'(fun_start_o), 32'd1);
        check("t1_fun_a", 32'(fun_a_o), 32'd3);
        check("t1_fun_b", 32'(fun_b_o), 32'd27);
        check("t1_level_e1", 32'(level_o), 32'd0);
        tick();
        check("t1_start_e2", 32'(fun_start_o), 32'd0);
        n = 0;
        while (!res_valid_o && n < 50) begin tick(); n++; end
        check("t1_valid", 32'(res_valid_o), 32'd1);
        check("t1_data", 32'(res_data_o), 32'd12);
        check("t1_tag", 32'(res_tag_o), 32'd0);
        repeat (3) tick();
        check("t1_hold_valid", 32'(res_valid_o), 32'd1);
        check("t1_hold_data", 32'(res_data_o), 32'd12);
        res_ready_i = 1'b1;
        wait_drain(100);

        // 2: four pairs back-to-back, tags 1..4
        push(8'd0, 8'd0, 16'd0);
        push(8'd15, 8'd8, 16'd227);
        push(8'd255, 8'd255, 16'd65031);
        push(8'd1, 8'd1, 16'd2);
        wait_drain(300);

        // 3: backpressure parks the FSM after the second start
        res_ready_i = 1'b0;
        s0 = start_cnt;
        push(8'd2, 8'd8, 16'd6);        // 4 + 2
        push(8'd5, 8'd64, 16'd29);      // 25 + 4
        push(8'd10, 8'd125, 16'd105);   // 100 + 5
        push(8'd7, 8'd1, 16'd50);       // 49 + 1
        repeat (40) tick();
        check("t3_starts", 32'(start_cnt - s0), 32'd2);
        check("t3_level", 32'(level_o), 32'd2);
        check("t3_valid", 32'(res_valid_o), 32'd1);
        check("t3_data", 32'(res_data_o), 32'd6);
        check("t3_tag", 32'(res_tag_o), 32'd5);
        repeat (5) tick();
        check("t3_data_stable", 32'(res_data_o), 32'd6);
        res_ready_i = 1'b1;
        tick();
        check("t3_next_valid", 32'(res_valid_o), 32'd1);
        check("t3_next_data", 32'(res_data_o), 32'd29);
        check("t3_next_tag", 32'(res_tag_o), 32'd6);

        // 4a: push coincides with pop at level 2 (100^2 + 3 = 10003)
        begin
            exp_t e;
            in_a_i     = 8'd100;
            in_b_i     = 8'd27;
            in_valid_i = 1'b1;
            e.data     = 16'd10003;
            e.tag      = tb_tag;
            exp_q.push_back(e);
            tb_tag     = tb_tag + 8'd1;
            tick();
            in_valid_i = 1'b0;
        end
        check("t4_level_same", 32'(level_o), 32'd2);
        check("t4_start_pop", 32'(fun_start_o), 32'd1);
        wait_drain(300);

        // 4b: fill to full, then pushes while full are dropped
        va[0] = 8'd1; va[1] = 8'd2; va[2] = 8'd3; va[3] = 8'd4; va[4] = 8'd5; va[5] = 8'd6;
        vr[0] = 16'd2; vr[1] = 16'd5; vr[2] = 16'd10; vr[3] = 16'd17; vr[4] = 16'd26; vr[5] = 16'd37;
        res_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) push(va[i], va[i], vr[i]);
        repeat (40) tick();
        check("t4_full_level", 32'(level_o), 32'd4);
        check("t4_full_ready", 32'(in_ready_o), 32'd0);
        in_a_i     = 8'hAA;
        in_b_i     = 8'hAA;
        in_valid_i = 1'b1;
        repeat (5) tick();
        in_valid_i = 1'b0;
        check("t4_full_level_hold", 32'(level_o), 32'd4);
        res_ready_i = 1'b1;
        wait_drain(500);
        check("t4_empty_after", 32'(level_o), 32'd0);

        // 5: 257 jobs from reset, tag wraps 255 -> 0 -> 1
        do_reset();
        res_ready_i = 1'b1;
        for (int i = 0; i < 257; i++) begin
            push(8'(i), 8'((i * 7) % 256), fun_ref(8'(i), 8'((i * 7) % 256)));
        end
        wait_drain(6000);
        check("t5_tag_counter", 32'(tb_tag), 32'd1);

        // 6a: reset during S_WAIT abandons the job (81 + 2 = 83)
        push(8'd9, 8'd9, 16'd83);
        n = 0;
        while (!fun_busy_i && n < 50) begin tick(); n++; end
        check("t6_busy_seen", 32'(fun_busy_i), 32'd1);
        do_reset();
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (res_valid_o) vcnt++;
        end
        check("t6_no_stale", 32'(vcnt), 32'd0);

        // 6b: fun never goes busy -> sticky error, stale result captured
        fault_mode = 1'b1;
        push(8'd3, 8'd27, 16'd0);
        repeat (10) tick();
        check("t6_err_set", 32'(err_o), 32'd1);
        wait_drain(100);
        repeat (20) tick();
        check("t6_err_sticky", 32'(err_o), 32'd1);
        fault_mode = 1'b0;
        do_reset();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
